// File: rtl/frame_pkg.sv
// Shared frame geometry, pixel types and the read-return tag used by the
// frame RAM arbiter and its tag pipeline.
package frame_pkg;

    localparam int unsigned FRAME_W      = 240;
    localparam int unsigned FRAME_H      = 320;
    localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int unsigned PIX_ADDR_W   = 17;
    localparam int unsigned PIX_DATA_W   = 16;

    typedef logic [PIX_ADDR_W-1:0] pix_addr_t;
    typedef logic [PIX_DATA_W-1:0] pix_data_t;

    typedef enum logic {
        RD_CORNERS  = 1'b0,
        RD_ISOLATOR = 1'b1
    } rd_client_e;

    typedef struct packed {
        logic       valid;
        rd_client_e id;
        logic       oob;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag shift register: delays {valid, reader, oob} by DEPTH cycles
// so it lines up with RAM read data. Synchronous flush drops in-flight reads.
module rd_tag_pipe
    import frame_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    flush,
    input  rd_tag_t head,
    output rd_tag_t tail
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= head;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail = stage[DEPTH-1];

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame BRAM arbiter: writer priority, round-robin between two
// readers, tagged read return. Optional starvation guard: FRAME_ARB_STARVE_GUARD_EN.
module frame_ram_arbiter
    import frame_pkg::*;
#(
    parameter int unsigned WIDTH       = FRAME_W,
    parameter int unsigned HEIGHT      = FRAME_H,
    parameter int unsigned ADDR_W      = PIX_ADDR_W,
    parameter int unsigned DATA_W      = PIX_DATA_W,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned STARVE_MAX  = 64
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_valid,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd_data_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned PIXELS = WIDTH * HEIGHT;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return 32'(a) >= PIXELS;
    endfunction

    logic              last_rd;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_any;
    logic              rd_sel;
    logic              wr_pick;
    logic              rd_pick;
    logic              starve_hit;
    logic [ADDR_W-1:0] rd_addr_sel;
    rd_tag_t           head;
    rd_tag_t           tail;

`ifdef FRAME_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign starve_hit = (32'(starve_cnt) == STARVE_MAX);

    // Counts cycles a waiting reader lost to the writer; saturates at STARVE_MAX.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            starve_cnt <= '0;
        end else if (rd_pick) begin
            starve_cnt <= '0;
        end else if (wr_pick && rd_any && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_hit = 1'b0 & (STARVE_MAX == 0);
`endif

    always_comb begin
        rd_any = rd0_req | rd1_req;
        if (rd0_req && rd1_req) begin
            rd_sel = ~last_rd;
        end else begin
            rd_sel = rd1_req;
        end
        wr_pick     = !rst_in && wr_req && !(starve_hit && rd_any);
        rd_pick     = !rst_in && rd_any && !wr_pick;
        rd_addr_sel = rd_sel ? rd1_addr : rd0_addr;
    end

    assign wr_gnt  = wr_pick;
    assign rd0_gnt = rd_pick && !rd_sel;
    assign rd1_gnt = rd_pick && rd_sel;
    assign ram_din = wr_data;

    // Address passes straight through on a grant and otherwise holds the last issued one.
    always_comb begin
        ram_addr = addr_q;
        ram_we   = 1'b0;
        if (rst_in) begin
            ram_addr = '0;
        end else if (wr_pick) begin
            ram_addr = wr_addr;
            ram_we   = !out_of_range(wr_addr);
        end else if (rd_pick) begin
            ram_addr = rd_addr_sel;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_rd <= 1'b1;
            addr_q  <= '0;
        end else begin
            addr_q <= ram_addr;
            if (rd_pick) begin
                last_rd <= rd_sel;
            end
        end
    end

    always_comb begin
        head.valid = rd_pick;
        head.id    = rd_sel ? RD_ISOLATOR : RD_CORNERS;
        head.oob   = out_of_range(rd_addr_sel);
    end

    rd_tag_pipe #(
        .DEPTH(RAM_LATENCY)
    ) u_tag_pipe (
        .clk  (clk_in),
        .flush(rst_in),
        .head (head),
        .tail (tail)
    );

    assign rd0_valid   = !rst_in && tail.valid && (tail.id == RD_CORNERS);
    assign rd1_valid   = !rst_in && tail.valid && (tail.id == RD_ISOLATOR);
    assign rd_data_out = (rst_in || !tail.valid || tail.oob) ? '0 : ram_dout;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench for frame_ram_arbiter: directed scenarios plus random
// traffic against a cycle-level reference model and a behavioural RAM.
module tb_frame_ram_arbiter;

    localparam int unsigned LAT    = 2;
    localparam int unsigned SMAX   = 4;
    localparam int unsigned PIXELS = 240 * 320;

`ifdef FRAME_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        wr_req, wr_gnt;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd0_req, rd0_gnt, rd0_valid;
    logic [16:0] rd0_addr;
    logic        rd1_req, rd1_gnt, rd1_valid;
    logic [16:0] rd1_addr;
    logic [15:0] rd_data_out;
    logic [16:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;

    always #5 clk_in = ~clk_in;

    frame_ram_arbiter #(
        .WIDTH      (240),
        .HEIGHT     (320),
        .ADDR_W     (17),
        .DATA_W     (16),
        .RAM_LATENCY(LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd0_req    (rd0_req),
        .rd0_addr   (rd0_addr),
        .rd0_gnt    (rd0_gnt),
        .rd0_valid  (rd0_valid),
        .rd1_req    (rd1_req),
        .rd1_addr   (rd1_addr),
        .rd1_gnt    (rd1_gnt),
        .rd1_valid  (rd1_valid),
        .rd_data_out(rd_data_out),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    // Behavioural single-port RAM with LAT-cycle read latency.
    logic [15:0] mem [131072];
    logic [15:0] rq  [LAT];

    always @(posedge clk_in) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        rq[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
    end
    assign ram_dout = rq[LAT-1];

    // Reference model state.
    typedef struct {
        int unsigned due;
        bit          who;
        logic [15:0] data;
    } ret_t;

    logic [15:0] shadow [PIXELS];
    ret_t        returns [$];
    bit          m_last;
    logic [16:0] m_addr;
    int unsigned m_wait;
    int unsigned cyc;
    int unsigned n_vec;
    int unsigned n_bad;
    bit          g_wr, g_r0, g_r1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [16:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r == 0) return 17'($urandom_range(PIXELS, 131071));
        if (r == 1) return 17'(PIXELS - 1);
        return 17'($urandom_range(0, 31));
    endfunction

    task automatic run_cycle();
        bit          e_wr, e_r0, e_r1, want_rd;
        logic [16:0] e_addr, ra;
        @(negedge clk_in);
        e_wr = 0; e_r0 = 0; e_r1 = 0;
        if (rst_in) begin
            check("rst_wr_gnt", wr_gnt, 0);
            check("rst_rd0_gnt", rd0_gnt, 0);
            check("rst_rd1_gnt", rd1_gnt, 0);
            check("rst_rd0_valid", rd0_valid, 0);
            check("rst_rd1_valid", rd1_valid, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_rd_data", rd_data_out, 0);
            returns.delete();
            m_last = 1; m_addr = '0; m_wait = 0;
        end else begin
            want_rd = rd0_req || rd1_req;
            if (wr_req && !(GUARD && want_rd && m_wait == SMAX)) e_wr = 1;
            else if (rd0_req && rd1_req) begin
                if (m_last) e_r0 = 1; else e_r1 = 1;
            end
            else if (rd0_req) e_r0 = 1;
            else if (rd1_req) e_r1 = 1;

            if (returns.size() > 0 && returns[0].due == cyc) begin
                check("rd0_valid", rd0_valid, returns[0].who == 1'b0);
                check("rd1_valid", rd1_valid, returns[0].who == 1'b1);
                check("rd_data", rd_data_out, returns[0].data);
                void'(returns.pop_front());
            end else begin
                check("rd0_valid_idle", rd0_valid, 0);
                check("rd1_valid_idle", rd1_valid, 0);
            end

            check("wr_gnt", wr_gnt, e_wr);
            check("rd0_gnt", rd0_gnt, e_r0);
            check("rd1_gnt", rd1_gnt, e_r1);

            ra     = e_r1 ? rd1_addr : rd0_addr;
            e_addr = e_wr ? wr_addr : (e_r0 || e_r1) ? ra : m_addr;
            check("ram_addr", ram_addr, e_addr);
            check("ram_we", ram_we, e_wr && wr_addr < PIXELS);
            if (e_wr && wr_addr < PIXELS) begin
                check("ram_din", ram_din, wr_data);
                shadow[wr_addr] = wr_data;
            end
            if (e_r0 || e_r1) begin
                returns.push_back('{cyc + LAT, e_r1, (ra < PIXELS) ? shadow[ra] : 16'h0});
                m_last = e_r1;
                m_wait = 0;
            end else if (e_wr && want_rd && m_wait < SMAX) begin
                m_wait++;
            end
            m_addr = e_addr;
        end
        g_wr = e_wr; g_r0 = e_r0; g_r1 = e_r1;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        g_wr = 0; g_r0 = 0; g_r1 = 0;
        for (int i = 0; i < 131072; i++) mem[i] = 16'(i * 7 + 3);
        mem[100] = 16'h1234;
        for (int i = 0; i < PIXELS; i++) shadow[i] = mem[i];
        rst_in = 1; wr_req = 0; rd0_req = 0; rd1_req = 0;
        wr_addr = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
        @(posedge clk_in); #1;

        // Reset holds every grant low even with all clients requesting.
        wr_req = 1; wr_addr = 17'd3; rd0_req = 1; rd1_req = 1;
        repeat (2) run_cycle();

        // Single reader.
        rst_in = 0; wr_req = 0; rd1_req = 0; rd0_addr = 17'd100;
        run_cycle();
        rd0_req = 0;
        repeat (3) run_cycle();

        // Reader tie.
        rd0_req = 1; rd1_req = 1; rd0_addr = 17'd10; rd1_addr = 17'd20;
        repeat (6) begin
            run_cycle();
            if (g_r0) rd0_addr = rd0_addr + 1'b1;
            if (g_r1) rd1_addr = rd1_addr + 1'b1;
        end
        rd0_req = 0; rd1_req = 0;
        repeat (3) run_cycle();

        // Write priority and read-after-write.
        wr_req = 1; wr_addr = 17'd5; wr_data = 16'hBEEF; rd0_req = 1; rd0_addr = 17'd5;
        run_cycle();
        wr_req = 0;
        run_cycle();
        rd0_req = 0;
        repeat (3) run_cycle();

        // Out of range read and write.
        rd1_req = 1; rd1_addr = 17'(PIXELS);
        run_cycle();
        rd1_req = 0; wr_req = 1; wr_addr = 17'(PIXELS + 1); wr_data = 16'hDEAD;
        run_cycle();
        wr_req = 0;
        repeat (3) run_cycle();
        check("oob_mem_untouched", mem[PIXELS + 1], 16'((PIXELS + 1) * 7 + 3));

        // Reset one cycle after a read grant; then first tie goes to rd0.
        rd1_req = 1; rd1_addr = 17'd7;
        run_cycle();
        rd1_req = 0; rst_in = 1;
        run_cycle();
        rst_in = 0; rd0_req = 1; rd1_req = 1; rd0_addr = 17'd8; rd1_addr = 17'd9;
        run_cycle();
        rd0_req = 0; rd1_req = 0;
        repeat (4) run_cycle();

        // Writer held with a waiting reader.
        wr_req = 1; rd1_req = 1; rd1_addr = 17'd11;
        repeat (15) begin
            run_cycle();
            if (g_wr) begin
                wr_addr = 17'($urandom_range(0, 63));
                wr_data = 16'($urandom);
            end
            if (g_r1) rd1_addr = 17'($urandom_range(0, 63));
        end
        wr_req = 0; rd1_req = 0;
        repeat (4) run_cycle();

        // Random traffic under the requester contract.
        for (int k = 0; k < 3000; k++) begin
            if (!wr_req || g_wr) begin
                wr_req  = ($urandom_range(0, 2) == 0);
                wr_addr = rand_addr();
                wr_data = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) wr_req = 0;
            if (!rd0_req || g_r0) begin
                rd0_req  = $urandom_range(0, 1) == 1;
                rd0_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) rd0_req = 0;
            if (!rd1_req || g_r1) begin
                rd1_req  = $urandom_range(0, 1) == 1;
                rd1_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) rd1_req = 0;
            rst_in = ($urandom_range(0, 399) == 0);
            run_cycle();
        end
        rst_in = 0; wr_req = 0; rd0_req = 0; rd1_req = 0;
        repeat (4) run_cycle();
        check("returns_drained", returns.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
